reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 105 ++++++++++
 tb/tb_reset_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronizes deassertion of rst, holds all domains in reset,
// then releases them one at a time in index order and tracks run time and sequence count.
module reset_sequencer #(
    parameter int NUM_DOMAINS     = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int HOLD_CYCLES     = 8,
    parameter int GAP_CYCLES      = 4,
    parameter int CYCLE_CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sw_reset_req,
    output logic [NUM_DOMAINS-1:0]     domain_rst,
    output logic                       all_released,
    output logic [CYCLE_CNT_WIDTH-1:0] cycle_count,
    output logic [7:0]                 reset_count
);

    localparam int MAX_WAIT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);
    localparam int IDX_W    = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

    generate
        if (NUM_DOMAINS < 1 || HOLD_CYCLES < 1 || GAP_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_params
            $error("reset_sequencer: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {SYNC, HOLD, RELEASE, RUN} state_t;

    state_t                 state;
    logic [SYNC_STAGES-2:0] sync_q;
    logic [CNT_W-1:0]       wait_cnt;
    logic [IDX_W-1:0]       idx;

    // Leaving SYNC acts as the final synchronizer stage, so T0 coincides with
    // the edge at which the full SYNC_STAGES-deep chain would first read 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_q << 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= SYNC;
            domain_rst   <= '1;
            all_released <= 1'b0;
            cycle_count  <= '0;
            reset_count  <= '0;
            wait_cnt     <= '0;
            idx          <= '0;
        end else if (state == SYNC) begin
            if (!sync_q[SYNC_STAGES-2]) begin
                state    <= HOLD;
                wait_cnt <= HOLD_LOAD;
                idx      <= '0;
            end
        end else if (sw_reset_req) begin
            state        <= HOLD;
            wait_cnt     <= HOLD_LOAD;
            idx          <= '0;
            domain_rst   <= '1;
            all_released <= 1'b0;
            cycle_count  <= '0;
        end else begin
            case (state)
                HOLD, RELEASE: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end else begin
                        domain_rst[idx] <= 1'b0;
                        wait_cnt        <= GAP_LOAD;
                        idx             <= idx + IDX_W'(1);
                        if (idx == LAST_IDX) begin
                            state        <= RUN;
                            all_released <= 1'b1;
                            cycle_count  <= '0;
                            if (reset_count != 8'hFF) begin
                                reset_count <= reset_count + 8'd1;
                            end
                        end else begin
                            state <= RELEASE;
                        end
                    end
                end
                RUN: begin
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + CYCLE_CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state <= SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: fixed timelines plus randomized sw_reset_req / rst glitches
// checked against a model that tracks edges since T0.
module tb_reset_sequencer;

    localparam int NUM_DOMAINS = 3;
    localparam int SYNC_STAGES = 2;
    localparam int HOLD        = 8;
    localparam int GAP         = 4;
    localparam int REL_LAST    = HOLD + (NUM_DOMAINS - 1) * GAP;

    logic        clk = 1'b0;
    logic        rst;
    logic        sw_reset_req = 1'b0;
    logic [2:0]  domain_rst;
    logic        all_released;
    logic [31:0] cycle_count;
    logic [7:0]  reset_count;
    logic [2:0]  domain_rst_b;
    logic        all_released_b;
    logic [3:0]  cycle_count_b;
    logic [7:0]  reset_count_b;

    int checks = 0;
    int errors = 0;

    reset_sequencer dut (
        .clk(clk), .rst(rst), .sw_reset_req(sw_reset_req),
        .domain_rst(domain_rst), .all_released(all_released),
        .cycle_count(cycle_count), .reset_count(reset_count)
    );

    reset_sequencer #(.CYCLE_CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .sw_reset_req(1'b0),
        .domain_rst(domain_rst_b), .all_released(all_released_b),
        .cycle_count(cycle_count_b), .reset_count(reset_count_b)
    );

    always #5 clk = ~clk;

    // Reference: count edges since the current T0; everything else follows arithmetically.
    int m_sync_cnt = 0;
    int m_k        = 0;
    bit m_active   = 1'b0;
    int m_rc       = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sync_cnt <= 0;
            m_active   <= 1'b0;
            m_k        <= 0;
            m_rc       <= 0;
        end else if (!m_active) begin
            if (m_sync_cnt == SYNC_STAGES - 1) begin
                m_active <= 1'b1;
                m_k      <= 0;
            end else begin
                m_sync_cnt <= m_sync_cnt + 1;
            end
        end else if (sw_reset_req) begin
            m_k <= 0;
        end else begin
            m_k <= m_k + 1;
            if (m_k + 1 == REL_LAST && m_rc < 255) m_rc <= m_rc + 1;
        end
    end

    function automatic logic [2:0] exp_dom();
        logic [2:0] d;
        for (int i = 0; i < NUM_DOMAINS; i++) d[i] = !m_active || (m_k < HOLD + i * GAP);
        return d;
    endfunction

    function automatic logic exp_all();
        return m_active && (m_k >= REL_LAST);
    endfunction

    function automatic longint exp_cyc(int width);
        longint v, mx;
        if (!(m_active && m_k >= REL_LAST)) return 0;
        v  = longint'(m_k - REL_LAST);
        mx = (longint'(1) << width) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(int cycles);
        rst = 1'b1;
        sw_reset_req = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called with rst just deasserted and E1 as the next rising edge; ends just after E23.
    task automatic run_timeline(string tag);
        logic [2:0] want;
        for (int e = 1; e <= 23; e++) begin
            step();
            want = (e < 10) ? 3'b111 : (e < 14) ? 3'b110 : (e < 18) ? 3'b100 : 3'b000;
            checks++;
            if (domain_rst !== want) begin
                errors++;
                $display("[TB] FAIL %s domain_rst E%0d: got %b expected %b", tag, e, domain_rst, want);
            end
            checks++;
            if (domain_rst !== exp_dom()) begin
                errors++;
                $display("[TB] FAIL %s model domain_rst E%0d: got %b expected %b", tag, e, domain_rst, exp_dom());
            end
            if (e == 17) begin
                checks++;
                if (all_released !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s all_released E17: got %b expected 0", tag, all_released);
                end
            end
            if (e == 18) begin
                checks++;
                if (all_released !== 1'b1 || reset_count !== 8'd1 || cycle_count !== 32'd0) begin
                    errors++;
                    $display("[TB] FAIL %s release E18: got all=%b rc=%0d cyc=%0d expected all=1 rc=1 cyc=0",
                             tag, all_released, reset_count, cycle_count);
                end
            end
            if (e == 23) begin
                checks++;
                if (cycle_count !== 32'd5) begin
                    errors++;
                    $display("[TB] FAIL %s cycle_count E23: got %0d expected 5", tag, cycle_count);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (domain_rst !== 3'b111 || all_released !== 1'b0 || cycle_count !== 32'd0 || reset_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got dom=%b all=%b cyc=%0d rc=%0d expected dom=111 all=0 cyc=0 rc=0",
                     domain_rst, all_released, cycle_count, reset_count);
        end
    endtask

    task automatic test_power_on();
        apply_reset(5);
        run_timeline("power_on");
    endtask

    task automatic test_sw_run();
        repeat (6) step();
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        checks++;
        if (domain_rst !== 3'b111 || all_released !== 1'b0 || cycle_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL sw_run E30: got dom=%b all=%b cyc=%0d expected dom=111 all=0 cyc=0",
                     domain_rst, all_released, cycle_count);
        end
        repeat (7) step();
        checks++;
        if (domain_rst !== 3'b111) begin
            errors++;
            $display("[TB] FAIL sw_run E37: got %b expected 111", domain_rst);
        end
        step();
        checks++;
        if (domain_rst !== 3'b110) begin
            errors++;
            $display("[TB] FAIL sw_run E38: got %b expected 110", domain_rst);
        end
        repeat (7) step();
        checks++;
        if (all_released !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sw_run E45: got all=%b expected 0", all_released);
        end
        step();
        checks++;
        if (all_released !== 1'b1 || reset_count !== 8'd2 || domain_rst !== 3'b000) begin
            errors++;
            $display("[TB] FAIL sw_run E46: got all=%b rc=%0d dom=%b expected all=1 rc=2 dom=000",
                     all_released, reset_count, domain_rst);
        end
    endtask

    task automatic test_sw_hold();
        apply_reset(3);
        repeat (5) step();
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        repeat (7) step();
        checks++;
        if (domain_rst !== 3'b111) begin
            errors++;
            $display("[TB] FAIL sw_hold E13: got %b expected 111", domain_rst);
        end
        step();
        checks++;
        if (domain_rst !== 3'b110) begin
            errors++;
            $display("[TB] FAIL sw_hold E14: got %b expected 110", domain_rst);
        end
        repeat (7) step();
        checks++;
        if (all_released !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sw_hold E21: got all=%b expected 0", all_released);
        end
        step();
        checks++;
        if (all_released !== 1'b1 || domain_rst !== 3'b000 || reset_count !== 8'd1) begin
            errors++;
            $display("[TB] FAIL sw_hold E22: got all=%b dom=%b rc=%0d expected all=1 dom=000 rc=1",
                     all_released, domain_rst, reset_count);
        end
    endtask

    task automatic test_mid_rst();
        apply_reset(3);
        repeat (15) step();
        checks++;
        if (domain_rst !== 3'b100) begin
            errors++;
            $display("[TB] FAIL mid_rst E15: got %b expected 100", domain_rst);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (domain_rst !== 3'b111 || reset_count !== 8'd0 || all_released !== 1'b0 || cycle_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL mid_rst async: got dom=%b rc=%0d all=%b cyc=%0d expected dom=111 rc=0 all=0 cyc=0",
                     domain_rst, reset_count, all_released, cycle_count);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_timeline("mid_rst");
    endtask

    task automatic test_glitch();
        #2;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (domain_rst !== 3'b111 || all_released !== 1'b0 || cycle_count !== 32'd0 || reset_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL glitch: got dom=%b all=%b cyc=%0d rc=%0d expected dom=111 all=0 cyc=0 rc=0",
                     domain_rst, all_released, cycle_count, reset_count);
        end
        run_timeline("glitch");
    endtask

    task automatic test_cycle_sat();
        for (int n = 0; n < 20; n++) begin
            step();
            checks++;
            if (cycle_count_b !== 4'(exp_cyc(4)) || domain_rst_b !== exp_dom() ||
                all_released_b !== exp_all() || reset_count_b !== 8'(m_rc)) begin
                errors++;
                $display("[TB] FAIL cycle_sat step %0d: got cyc=%0d dom=%b all=%b rc=%0d expected cyc=%0d dom=%b all=%b rc=%0d",
                         n, cycle_count_b, domain_rst_b, all_released_b, reset_count_b,
                         exp_cyc(4), exp_dom(), exp_all(), m_rc);
            end
        end
        checks++;
        if (cycle_count_b !== 4'd15) begin
            errors++;
            $display("[TB] FAIL cycle_sat hold: got %0d expected 15", cycle_count_b);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            sw_reset_req = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                #2;
                rst = 1'b0;
            end
            step();
            checks++;
            if (domain_rst !== exp_dom() || all_released !== exp_all() ||
                cycle_count !== 32'(exp_cyc(32)) || reset_count !== 8'(m_rc)) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got dom=%b all=%b cyc=%0d rc=%0d expected dom=%b all=%b cyc=%0d rc=%0d",
                         n, domain_rst, all_released, cycle_count, reset_count,
                         exp_dom(), exp_all(), exp_cyc(32), m_rc);
            end
        end
        sw_reset_req = 1'b0;
    endtask

    task automatic test_reset_sat();
        apply_reset(2);
        repeat (20) step();
        for (int n = 0; n < 300; n++) begin
            sw_reset_req = 1'b1;
            step();
            sw_reset_req = 1'b0;
            repeat (REL_LAST) step();
            checks++;
            if (reset_count !== 8'(m_rc) || all_released !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_sat seq %0d: got rc=%0d all=%b expected rc=%0d all=1",
                         n, reset_count, all_released, m_rc);
            end
        end
        checks++;
        if (reset_count !== 8'd255) begin
            errors++;
            $display("[TB] FAIL reset_sat final: got %0d expected 255", reset_count);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_power_on();
        test_sw_run();
        test_sw_hold();
        test_mid_rst();
        test_glitch();
        test_cycle_sat();
        test_random();
        test_reset_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
